// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scan controller with a frame-aligned load/ack handshake.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
//
// state | meaning
// BLANK | all digits off for BLANK_CYCLES before the next digit
// SHOW  | digit[index] driven with its decoded nibble for DWELL_CYCLES
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  input  logic                    i_Load,
  output logic                    o_Load_Ack,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic [6:0]              o_Segments,
  output logic                    o_Frame_Start
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   active_q, active_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            frame_d, commit;
  logic [NUM_DIGITS-1:0] en_d, sup;
  logic [6:0]      seg_d;
  logic [3:0]      nib;

  // Active-high {G,F,E,D,C,B,A}; the bus is driven with the complement.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame_d = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
          frame_d = (idx_q == '0);
        end
      end
      default: begin
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
    endcase

    commit    = frame_d && (pending_q || i_Load);
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (i_Load) begin
      shadow_d  = i_Digits;
      pending_d = 1'b1;
    end
    // A load landing on the commit edge bypasses the shadow register.
    if (commit) begin
      active_d  = i_Load ? i_Digits : shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IW'(i)) nib = active_d[4*i +: 4];

    sup = '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        lead   = lead && (active_d[4*i +: 4] == 4'h0);
        sup[i] = lead;
      end
    end
`endif

    en_d  = '0;
    seg_d = 7'h7F;
    if (state_d == SHOW && !sup[idx_d]) begin
      en_d[idx_d] = 1'b1;
      seg_d       = ~hex_seg(nib);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      o_Digit_En    <= '0;
      o_Segments    <= 7'h7F;
      o_Load_Ack    <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      o_Digit_En    <= en_d;
      o_Segments    <= seg_d;
      o_Load_Ack    <= commit;
      o_Frame_Start <= frame_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (4 digits, dwell 8, blank 2, frame 40).
module tb_seven_segment_scan_controller;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic [15:0] i_Digits;
  logic        i_Load;
  logic        o_Load_Ack;
  logic [3:0]  o_Digit_En;
  logic [6:0]  o_Segments;
  logic        o_Frame_Start;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seven_segment_scan_controller #(
    .NUM_DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Digits(i_Digits), .i_Load(i_Load),
    .o_Load_Ack(o_Load_Ack), .o_Digit_En(o_Digit_En), .o_Segments(o_Segments),
    .o_Frame_Start(o_Frame_Start)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then sample 1 time unit later; cyc counts edges since reset release.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] en, input logic [6:0] seg);
    chk({tag, "_en"}, o_Digit_En, en);
    chk({tag, "_seg"}, o_Segments, seg);
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Load   = 1'b0;
    i_Digits = 16'h0000;
    #12;
    chk_slot("rst", 4'b0000, 7'h7F);
    chk("rst_ack", o_Load_Ack, 1'b0);
    chk("rst_fs", o_Frame_Start, 1'b0);
    #10 i_Rst_L = 1'b1;

    tick_to(1);  chk_slot("blank0", 4'b0000, 7'h7F);
    tick_to(2);  chk_slot("d0_first", 4'b0001, 7'h40);
    chk("fs_first", o_Frame_Start, 1'b1);
    tick_to(3);  chk("fs_pulse", o_Frame_Start, 1'b0);
    tick_to(9);  chk_slot("d0_last", 4'b0001, 7'h40);
    tick_to(10); chk_slot("blank1", 4'b0000, 7'h7F);
    tick_to(12); chk_slot("d1_zero", 4'b0010, 7'h40);
    tick_to(41); chk("fs_before", o_Frame_Start, 1'b0);
    tick_to(42); chk("fs_period", o_Frame_Start, 1'b1);

    // Mid-frame load commits at the next frame start.
    i_Digits = 16'h1234; i_Load = 1'b1;
    tick(); i_Load = 1'b0;
    chk("ack_early", o_Load_Ack, 1'b0);
    tick_to(81);  chk("ack_pre", o_Load_Ack, 1'b0);
    tick_to(82);  chk("ack_1234", o_Load_Ack, 1'b1);
    chk_slot("v1234_d0", 4'b0001, 7'h19);
    tick_to(83);  chk("ack_1234_pulse", o_Load_Ack, 1'b0);
    tick_to(92);  chk_slot("v1234_d1", 4'b0010, 7'h30);
    tick_to(102); chk_slot("v1234_d2", 4'b0100, 7'h24);
    tick_to(112); chk_slot("v1234_d3", 4'b1000, 7'h79);

    // Two loads before commit: latest wins, single ack.
    tick_to(124); i_Digits = 16'h1111; i_Load = 1'b1;
    tick(); i_Load = 1'b0;
    tick_to(129); i_Digits = 16'h2222; i_Load = 1'b1;
    tick(); i_Load = 1'b0;
    tick_to(161); chk("ack2_pre", o_Load_Ack, 1'b0);
    tick_to(162); chk("ack2", o_Load_Ack, 1'b1);
    chk_slot("v2222_d0", 4'b0001, 7'h24);
    tick_to(172); chk_slot("v2222_d1", 4'b0010, 7'h24);
    tick_to(192); chk_slot("v2222_d3", 4'b1000, 7'h24);
    tick_to(202); chk("ack2_single", o_Load_Ack, 1'b0);
    chk("fs_202", o_Frame_Start, 1'b1);

    // Load on the last blank cycle before digit 0: one-cycle latency.
    tick_to(241); chk("ack3_pre", o_Load_Ack, 1'b0);
    i_Digits = 16'hBCDE; i_Load = 1'b1;
    tick(); i_Load = 1'b0;
    chk("ack3_min", o_Load_Ack, 1'b1);
    chk_slot("vBCDE_d0", 4'b0001, 7'h06);
    tick_to(243); chk("ack3_pulse", o_Load_Ack, 1'b0);
    tick_to(252); chk_slot("vBCDE_d1", 4'b0010, 7'h21);
    tick_to(262); chk_slot("vBCDE_d2", 4'b0100, 7'h46);
    tick_to(272); chk_slot("vBCDE_d3", 4'b1000, 7'h03);
    tick_to(282); chk("ack3_no_repeat", o_Load_Ack, 1'b0);

    // Leading zeros: shown by default, suppressed with the macro.
    tick_to(290); i_Digits = 16'h0005; i_Load = 1'b1;
    tick(); i_Load = 1'b0;
    tick_to(322); chk("ack4", o_Load_Ack, 1'b1);
    chk_slot("v0005_d0", 4'b0001, 7'h12);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    tick_to(332); chk_slot("v0005_d1", 4'b0000, 7'h7F);
    tick_to(342); chk_slot("v0005_d2", 4'b0000, 7'h7F);
`else
    tick_to(332); chk_slot("v0005_d1", 4'b0010, 7'h40);
    tick_to(342); chk_slot("v0005_d2", 4'b0100, 7'h40);
`endif

    // Asynchronous reset in the middle of digit 2's slot.
    tick_to(345);
    #2 i_Rst_L = 1'b0;
    #1;
    chk_slot("async_rst", 4'b0000, 7'h7F);
    chk("async_rst_fs", o_Frame_Start, 1'b0);
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    cyc = 0;
    tick_to(1); chk_slot("re_blank", 4'b0000, 7'h7F);
    tick_to(2); chk_slot("re_d0", 4'b0001, 7'h40);
    chk("re_fs", o_Frame_Start, 1'b1);
    chk("re_ack", o_Load_Ack, 1'b0);
    tick_to(12); chk_slot("re_d1", 4'b0010, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_controller.md
# seven_segment_scan_controller

Time-multiplexed scan controller for a bank of common-segment seven-segment digits. It shares one hex decoder and one active-low segment bus between `NUM_DIGITS` digits by cycling a one-hot digit enable. Each digit gets a blanking gap before it is driven, to prevent ghosting. New display values are accepted through a load/acknowledge handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the counter/datapath logic and the board's segment and digit-select pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of scanned digits; must be 2..8.
- `DWELL_CYCLES`, 25000: clock cycles each digit is driven; must be ≥ 1.
- `BLANK_CYCLES`, 250: cycles with all digits off before each digit; must be ≥ 1.

Ports:
- `i_Clk`  in  1  system clock; the only clock in the block.
- `i_Rst_L`  in  1  reset; asynchronous assert, active-low.
- `i_Digits`  in  4*NUM_DIGITS  BCD/hex nibbles; nibble 0 (bits 3:0) is the least significant digit.
- `i_Load`  in  1  single-cycle request to capture `i_Digits`.
- `o_Load_Ack`  out  1  one-cycle pulse when the captured value becomes the displayed value.
- `o_Digit_En`  out  NUM_DIGITS  one-hot, active-high digit enable.
- `o_Segments`  out  7  active-low segments, ordered {G,F,E,D,C,B,A}.
- `o_Frame_Start`  out  1  one-cycle pulse on the first SHOW cycle of digit 0.

## Operation
- Registers:
  - shadow register, 4*NUM_DIGITS bits;
  - active register, 4*NUM_DIGITS bits;
  - pending flag;
  - digit index, 0..NUM_DIGITS-1;
  - cycle counter, sized for max(DWELL_CYCLES, BLANK_CYCLES);
  - FSM with two states, BLANK and SHOW.
- BLANK:
  - `o_Digit_En` = 0 and `o_Segments` = 7'h7F.
  - After BLANK_CYCLES cycles, go to SHOW and clear the counter.
- SHOW:
  - `o_Digit_En[index]` = 1.
  - `o_Segments` = ~decode(active nibble[index]).
  - After DWELL_CYCLES cycles, go to BLANK and advance the index, wrapping from NUM_DIGITS-1 to 0.
- Decoder: full hex 0-F, standard glyphs, lowercase b and d.
- Load:
  - `i_Load`=1 writes `i_Digits` into the shadow register and sets pending.
  - A second load before commit overwrites the shadow register; the latest value wins and only one ack is produced.
- Commit:
  - Occurs on the BLANK→SHOW transition with index 0, when pending=1.
  - Active ← shadow, pending is cleared, and `o_Load_Ack` pulses in the first SHOW cycle of digit 0.
  - The new value is displayed from that cycle on.
- Load coinciding with commit: `i_Digits` on that cycle is committed directly. The ack still pulses and pending ends cleared.
- Reset (asynchronous, any state, including mid-SHOW):
  - FSM = BLANK, index = 0, counter = 0;
  - active = 0, shadow = 0, pending = 0;
  - `o_Digit_En` = 0, `o_Segments` = 7'h7F;
  - `o_Load_Ack` = 0, `o_Frame_Start` = 0.

## Timing
- All outputs are registered and reflect the FSM state of the same cycle (registered from next-state).
- After reset release, the first BLANK lasts BLANK_CYCLES cycles. `o_Digit_En[0]` then rises for DWELL_CYCLES cycles.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. `o_Frame_Start` repeats with exactly this period.
- Load-to-ack latency:
  - minimum 1 cycle, when the load lands on the last BLANK cycle before digit 0;
  - maximum one frame period.
- `i_Load` needs no ready signal and is never dropped.
- Digit enables never overlap. At least BLANK_CYCLES cycles separate any two enables.

## Configuration
- `SEVEN_SEG_LEADING_ZERO_BLANK_EN` defined:
  - Zero-valued digits from index NUM_DIGITS-1 downward, up to the first nonzero digit, are suppressed.
  - A suppressed digit's SHOW slot keeps `o_Digit_En` = 0 and `o_Segments` = 7'h7F, with unchanged slot timing.
  - Digit 0 is always shown.
- Not defined: every digit is always shown, including leading zeros.

## Test plan
Bench parameters: NUM_DIGITS=4, DWELL=8, BLANK=2 (frame = 40 cycles).
- Reset release → enables 0 and segments 7'h7F for 2 cycles; `o_Digit_En`=4'b0001 for 8 cycles with segments 7'h40 (digit 0); `o_Frame_Start` pulses every 40 cycles.
- `i_Load` with 16'h1234 mid-frame → ack at the next frame start; digit slots 0..3 show 7'h19, 7'h30, 7'h24, 7'h79.
- Loads of 16'h1111 then 16'h2222 before commit → single ack; all digits show 7'h24.
- `i_Load` on the last BLANK cycle before digit 0 → ack on the next cycle; the new value appears in that same frame.
- Assert `i_Rst_L`=0 mid-SHOW of digit 2 → outputs go to 0/7'h7F immediately (asynchronously); after release, the scan restarts at digit 0 showing 0.
- Load 16'h0005:
  - with `SEVEN_SEG_LEADING_ZERO_BLANK_EN` → the digit 3..1 slots keep enables low, and digit 0 shows 7'h12;
  - without it → digits 3..1 show 7'h40.
